// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the elastic pipeline register.
// State encoding doubles as the occupancy count.
package pipe_pkg;

  localparam int PIPE_CNT_W = 2;

  typedef enum logic [PIPE_CNT_W-1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_skid_reg_dffre_sync.sv
// dffre_sync: enable register, synchronous active-high
// reset to RESET_VAL.
module dffre_sync #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer, registered in_ready.
// Optional flush port under PIPE_SKID_FLUSH_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [PIPE_CNT_W-1:0] count
`ifdef PIPE_SKID_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  pipe_state_t      state_q;
  pipe_state_t      state_n;
  logic             in_ready_q;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;
  logic             do_flush;

`ifdef PIPE_SKID_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_n = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_n = BUSY;
          main_en = 1'b1;
        end
      end
      BUSY: begin
        if (in_fire && !out_fire) begin
          state_n = FULL;
          skid_en = 1'b1;
        end else if (out_fire && !in_fire) begin
          state_n = EMPTY;
        end else if (in_fire && out_fire) begin
          main_en = 1'b1;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_n = BUSY;
          main_en = 1'b1;
          main_d  = skid_q;
        end
      end
      default: state_n = EMPTY;
    endcase
    // Flush drops held beats and any concurrent accept
    if (do_flush) begin
      state_n = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_n;
      in_ready_q <= (state_n != FULL);
    end
  end

  dffre_sync #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  dffre_sync #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline register for the CPU datapath: a two-entry skid buffer with valid/ready handshake, flush and occupancy reporting. It sits between pipeline stages, e.g. IF→ID or EX→MEM. It replaces bare enable-gated state registers wherever back-pressure must stall a producer without a combinational ready path, and it sustains one transfer per cycle.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- RESET_VAL, {WIDTH{1'b0}}: value loaded into both data entries on reset.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  buffer accepts; registered, no combinational path from any input.
- in_data  input  WIDTH  payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  payload head (main entry).
- count  output  2  occupancy, 0..2.
- flush  input  1  discard all held and incoming beats (present only with PIPE_SKID_FLUSH_EN).

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- States: EMPTY (count 0), BUSY (count 1), FULL (count 2).
- out_valid = (state != EMPTY); in_ready = (state != FULL), held in a flop updated from next-state.
- EMPTY: in_fire → BUSY, main ← in_data.
- BUSY: in_fire & !out_fire → FULL, skid ← in_data; out_fire & !in_fire → EMPTY; both → BUSY, main ← in_data; neither → hold.
- FULL: out_fire → BUSY, main ← skid. in_ready = 0, so no accept.
- Order is preserved; no beat is duplicated or dropped except by flush.
- Unsigned 2-bit count equals the number of held beats; no wrap because it saturates structurally at 2.
- Data registers change only on the loads listed above; out_data is stable while out_valid & !out_ready.

## Timing
- Latency 1 cycle: a beat accepted at edge N is on out_data/out_valid after edge N.
- Throughput 1 beat/cycle while out_ready stays high.
- At the edge where rst = 1: state ← EMPTY, main and skid ← RESET_VAL, in_ready ← 1, count ← 0. out_valid = 0 and out_data = RESET_VAL after that edge.
- Reset takes priority over everything. Handshake inputs are ignored at any edge with rst = 1, including mid-transfer and when FULL.
- in_ready falls in the cycle after the edge that entered FULL. It rises in the cycle after the edge that leaves FULL.
- Producers must hold in_valid/in_data until in_fire; consumers see the same guarantee on out.

## Configuration
- PIPE_SKID_FLUSH_EN defined: flush port exists. At an edge with flush = 1 and rst = 0: state ← EMPTY, count ← 0, in_ready ← 1.
  - Any simultaneous in_fire beat is discarded.
  - Data registers keep their contents. out_valid = 0 next cycle.
  - Flush outranks in/out fires in the same cycle.
- Undefined: no flush port, and no flush logic is synthesised.

## Structure
- Package pipe_pkg: state typedef pipe_state_t (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) and constant PIPE_CNT_W = 2.
- count is derived directly from the state encoding.
- One sub-module: dffre_sync, a WIDTH-parametrised enable register with synchronous active-high reset to RESET_VAL. It is instantiated twice, for main and skid.

## Test plan
- Reset: hold rst 1 with in_valid = 1 and in_data = 32'hDEAD_BEEF → after release out_valid = 0, out_data = 0, in_ready = 1, count = 0.
- Streaming: out_ready = 1, send 1,2,3,4 on consecutive cycles → out_data 1,2,3,4 each one cycle later, in_ready stays 1, count = 1.
- Back-pressure: out_ready = 0, send 5 then 6 → count = 2, in_ready = 0 next cycle, out_data = 5. Raise out_ready → 5, then 6, then out_valid = 0.
- Simultaneous fire in BUSY: hold 7, in_fire(8) with out_fire → out_data = 8, count stays 1.
- Flush (PIPE_SKID_FLUSH_EN): FULL with 9,10, then flush = 1 with in_valid = 1, in_data = 11 → out_valid = 0, count = 0, in_ready = 1, and 11 never appears.
- Reset mid-operation: FULL, assert rst for one edge → count = 0, out_data = RESET_VAL, no stale beat emitted afterwards.
